// File: rtl/sm4_dec_iter.sv
// Iterative SM4 block decryptor. Each clock runs one round, so a block takes 32 rounds.
// A single round datapath is reused for every round. Round keys are fetched from the
// key-expansion block in reverse order, starting with rk_31.
module sm4_dec_iter #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sm4_enable,
  input  logic         key_exp_out,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [4:0]   rk_addr,
  input  logic [31:0]  rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] res_out
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  localparam logic [2047:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_p0;
  state_t         state_nx;
  logic [4:0]     cnt_p0;
  logic [127:0]   x_p0;
  logic [31:0]    f_rnd;
  logic           last_rnd;

  // Byte 0x00 sits at the most significant end of the table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] idx;
    idx = {~a, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] b);
    return {sbox(b[31:24]), sbox(b[23:16]), sbox(b[15:8]), sbox(b[7:0])};
  endfunction

  // Linear diffusion: B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
  function automatic logic [31:0] l_lin(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
             ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  // One round of the encryption round function. Decryption only reverses the key order.
  function automatic logic [31:0] one_round_enc(input logic [127:0] x, input logic [31:0] rk);
    return x[127:96] ^ l_lin(tau(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk));
  endfunction

  // ---- round datapath: combinational, between the X register and itself ----
  assign f_rnd    = one_round_enc(x_p0, rk_data);
  assign last_rnd = (cnt_p0 == LAST);

  // Next-state logic, input handshake and round-key index.
  always_comb begin
    state_nx = state_p0;
    in_ready = 1'b0;
    rk_addr  = LAST;
    case (state_p0)
      IDLE: begin
        in_ready = sm4_enable & key_exp_out & ~rst;
        if (in_valid && in_ready) state_nx = RUN;
      end
      RUN: begin
        rk_addr = LAST - cnt_p0;
        if (!sm4_enable)   state_nx = IDLE;
        else if (last_rnd) state_nx = DONE;
      end
      DONE: begin
        if (!sm4_enable || out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- state register: round counter, X, result and output valid ----
  // Registers update on the rising edge. An enable drop discards the block in flight but keeps res_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      cnt_p0    <= '0;
      x_p0      <= '0;
      res_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      case (state_p0)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_p0   <= data_in;
            cnt_p0 <= '0;
          end
        end
        RUN: begin
          if (sm4_enable) begin
            x_p0   <= {x_p0[95:0], f_rnd};
            cnt_p0 <= last_rnd ? '0 : cnt_p0 + 5'd1;
            if (last_rnd) begin
              res_out   <= {f_rnd, x_p0[31:0], x_p0[63:32], x_p0[95:64]};
              out_valid <= 1'b1;
            end
          end else begin
            cnt_p0    <= '0;
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          if (!sm4_enable || out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_dec_iter.sv
// Bench for sm4_dec_iter. It models SM4 key expansion and the cipher with the textbook
// X[i+4] recurrence, then drives fixed and random blocks through the design.
module tb_sm4_dec_iter;

  localparam logic [127:0] KEY1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT1  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] PT1  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] FK   = {32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [2047:0] SBOX_M = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic         clk = 1'b0;
  logic         rst, sm4_enable, key_exp_out, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [127:0] data_in, res_out;
  logic [4:0]   rk_addr;
  logic [31:0]  rk_data;
  logic [31:0]  rk_mem [32];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           acc_cyc = 0;

  sm4_dec_iter #(.ROUNDS(32)) dut (
    .clk(clk), .rst(rst), .sm4_enable(sm4_enable), .key_exp_out(key_exp_out),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .rk_addr(rk_addr), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .res_out(res_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rk_data = rk_mem[rk_addr];

  // ---------------- reference model ----------------
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [10:0] idx;
    idx = 11'(255 - int'(a)) * 11'd8;
    return SBOX_M[idx +: 8];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau_m(input logic [31:0] a);
    return {sb(a[31:24]), sb(a[23:16]), sb(a[15:8]), sb(a[7:0])};
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] a);
    logic [31:0] b;
    b = tau_m(a);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau_m(a);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  task automatic key_expand(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck;
    for (int j = 0; j < 4; j++) k[j] = mk[127 - 32*j -: 32] ^ FK[127 - 32*j -: 32];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk_mem[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] sm4_crypt(input logic [127:0] blk, input bit dec);
    logic [31:0] xw [36];
    int ki;
    for (int j = 0; j < 4; j++) xw[j] = blk[127 - 32*j -: 32];
    for (int i = 0; i < 32; i++) begin
      ki = dec ? 31 - i : i;
      xw[i+4] = xw[i] ^ t_enc(xw[i+1] ^ xw[i+2] ^ xw[i+3] ^ rk_mem[ki]);
    end
    return {xw[35], xw[34], xw[33], xw[32]};
  endfunction

  // ---------------- checking and sequencing ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Offer a block and wait (bounded) until it is taken on the next rising edge.
  task automatic accept(input logic [127:0] ct);
    int w;
    w = 0;
    data_in  = ct;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", in_ready, 1);
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Step n rounds, checking the reverse key index and that no result is shown yet.
  task automatic run_rounds(input int n);
    for (int i = 0; i < n; i++) begin
      check("rk_addr", rk_addr, 31 - i);
      check("ov_low_run", out_valid, 0);
      @(negedge clk);
    end
  endtask

  task automatic expect_out(input logic [127:0] exp);
    check("out_valid", out_valid, 1);
    check("res_out", res_out, exp);
    if (out_ready) begin
      @(negedge clk);
      check("ov_clear", out_valid, 0);
    end
  endtask

  task automatic send_full(input logic [127:0] ct, input logic [127:0] exp);
    accept(ct);
    run_rounds(32);
    expect_out(exp);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] held, ct, mk, zexp;
    int a0, d;
    bit seen;

    rst = 1'b1; sm4_enable = 1'b0; key_exp_out = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    key_expand(KEY1);
    repeat (2) @(negedge clk);
    check("rst_ov", out_valid, 0);
    check("rst_res", res_out, 0);
    check("rst_rk", rk_addr, 31);
    check("rst_in_ready", in_ready, 0);
    // Reset outranks an otherwise acceptable offer.
    sm4_enable = 1'b1; key_exp_out = 1'b1; in_valid = 1'b1; data_in = CT1;
    #1 check("rst_blocks_accept", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_rk", rk_addr, 31);

    // 1: known-answer decryption
    send_full(CT1, PT1);

    // 2: output backpressure
    zexp = sm4_crypt(128'h0, 1'b1);
    out_ready = 1'b0;
    accept(CT1);
    run_rounds(32);
    expect_out(PT1);
    data_in = 128'h0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_ov", out_valid, 1);
      check("bp_res", res_out, PT1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ov", out_valid, 0);
    check("bp_next_ready", in_ready, 1);
    accept(128'h0);
    run_rounds(32);
    expect_out(zexp);

    // 3: key expansion not ready blocks acceptance
    key_exp_out = 1'b0; data_in = CT1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nokey_in_ready", in_ready, 0);
      check("nokey_rk", rk_addr, 31);
    end
    key_exp_out = 1'b1;
    #1 check("key_in_ready", in_ready, 1);
    accept(CT1);
    run_rounds(32);
    expect_out(PT1);

    // 4: enable dropped mid-block
    accept(128'h0);
    run_rounds(10);
    sm4_enable = 1'b0;
    @(negedge clk);
    check("abort_rk", rk_addr, 31);
    check("abort_in_ready", in_ready, 0);
    check("abort_res_kept", res_out, PT1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_ov", seen, 0);
    sm4_enable = 1'b1;
    send_full(CT1, PT1);

    // 5: reset mid-run and in DONE
    accept(CT1);
    run_rounds(20);
    rst = 1'b1;
    @(negedge clk);
    check("rrun_ov", out_valid, 0);
    check("rrun_res", res_out, 0);
    check("rrun_rk", rk_addr, 31);
    check("rrun_in_ready", in_ready, 0);
    rst = 1'b0;
    send_full(128'h0, zexp);
    out_ready = 1'b0;
    accept(CT1);
    run_rounds(32);
    check("rdone_pre_ov", out_valid, 1);
    out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rdone_ov", out_valid, 0);
    check("rdone_res", res_out, 0);
    check("rdone_rk", rk_addr, 31);
    rst = 1'b0;
    @(negedge clk);
    send_full(CT1, PT1);

    // 6: back-to-back blocks
    send_full(CT1, PT1);
    a0 = acc_cyc;
    send_full(128'h0, zexp);
    d = acc_cyc - a0;
    check("b2b_spacing", d, 34);

    // random keys, ciphertexts and output stalls
    for (int n = 0; n < 6; n++) begin
      mk = {$urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      key_expand(mk);
      out_ready = $urandom_range(0, 1) == 1;
      accept(ct);
      run_rounds(32);
      held = sm4_crypt(ct, 1'b1);
      check("rnd_ov", out_valid, 1);
      check("rnd_res", res_out, held);
      check("rnd_inverse", sm4_crypt(res_out, 1'b0), ct);
      if (!out_ready) begin
        repeat ($urandom_range(1, 5)) begin
          @(negedge clk);
          check("rnd_hold", res_out, held);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      check("rnd_ov_clear", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
